// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status-bit positions and the
// rule deciding which opcodes write the architectural flags.
package alu_pkg;

  localparam int STATUS_W = 6;

  localparam int ST_C  = 5;
  localparam int ST_Z  = 4;
  localparam int ST_N  = 3;
  localparam int ST_V  = 2;
  localparam int ST_P  = 1;
  localparam int ST_AF = 0;

  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_ADC = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SBB = 3'b111;

  typedef logic [STATUS_W-1:0] status_t;

  // Opcodes 000 and 010 produce results that never touch the flag register.
  function automatic logic op_writes_flags(input logic [2:0] op);
    logic hit;
    case (op)
      OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB: hit = 1'b1;
      default:                                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Two-entry valid/ready buffer with registered pointers; the write side is
// held off until the first clock edge after reset has been released.
module result_fifo #(
  parameter int DataW = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DataW-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DataW-1:0] rd_data,
  output logic [1:0]       count
);

  logic [DataW-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic             live_q;
  logic             push;
  logic             pop;

  // Readiness comes only from registered state, never from rd_ready.
  assign wr_ready = live_q && (count_q < 2'd2);
  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = mem[rd_ptr];
  assign count    = count_q;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers {result, status} for the consumer and maintains
// the architectural flag register and a saturating overflow counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int Width     = 16,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Width-1:0]     in_out,
  input  logic [STATUS_W-1:0]  in_status,
  input  logic [2:0]           in_op,
  input  logic                 in_flag_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width-1:0]     out_data,
  output logic [STATUS_W-1:0]  out_status,
  output logic [STATUS_W-1:0]  flags,
  output logic                 cin_fb,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic [1:0]           occupancy
);

  localparam int EntryW = Width + STATUS_W;

  logic [EntryW-1:0] head;
  logic              push;

  result_fifo #(
    .DataW(EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_valid(in_valid),
    .wr_ready(in_ready),
    .wr_data ({in_out, in_status}),
    .rd_valid(out_valid),
    .rd_ready(out_ready),
    .rd_data (head),
    .count   (occupancy)
  );

  assign out_data   = head[STATUS_W +: Width];
  assign out_status = head[STATUS_W-1:0];

  assign push = in_valid && in_ready;

  // Flags follow the accepted result immediately, not when it drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (push && in_flag_we && op_writes_flags(in_op)) begin
      flags <= in_status;
    end
  end

  assign cin_fb = flags[ST_C];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (push && in_status[ST_V] && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed bench for alu_result_stage against a queue-based
// reference model of the buffer, flag register and overflow counter.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_out;
  logic [5:0]  in_status;
  logic [2:0]  in_op;
  logic        in_flag_we;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [5:0]  out_status;
  logic [5:0]  flags;
  logic        cin_fb;
  logic [7:0]  ovf_cnt;
  logic [1:0]  occupancy;

  int checks   = 0;
  int failures = 0;

  logic [21:0] q[$];
  logic [5:0]  flags_m;
  int          ovf_m;
  bit          live_m;

  alu_result_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_out    (in_out),
    .in_status (in_status),
    .in_op     (in_op),
    .in_flag_we(in_flag_we),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_status(out_status),
    .flags     (flags),
    .cin_fb    (cin_fb),
    .ovf_cnt   (ovf_cnt),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: one clock edge with the currently driven inputs.
  task automatic cycle();
    bit push, pop;
    push = in_valid && live_m && (q.size() < 2);
    pop  = out_ready && (q.size() > 0);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back({in_out, in_status});
      if (in_flag_we && in_op != 3'b000 && in_op != 3'b010) flags_m = in_status;
      if (in_status[2] && ovf_m < 255) ovf_m++;
    end
    live_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    flags_m = '0;
    ovf_m   = 0;
    live_m  = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_out = '0; in_status = '0; in_op = '0; in_flag_we = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_data !== 16'h0 || out_status !== 6'h0) begin failures++; $display("FAIL reset_out got=%h/%b exp=0", out_data, out_status); end
    checks++; if (flags !== 6'h0 || ovf_cnt !== 8'h0) begin failures++; $display("FAIL reset_regs flags=%b ovf=%0d exp=0", flags, ovf_cnt); end
    // A push offered in the release cycle must be ignored.
    rst = 1'b0;
    in_valid = 1; in_out = 16'hBEEF; in_status = 6'b000100; in_op = 3'b100; in_flag_we = 1; out_ready = 1;
    cycle();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL release_push occ=%0d valid=%b exp=0/0", occupancy, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (flags !== flags_m || ovf_cnt !== 8'(ovf_m)) begin failures++; $display("FAIL release_regs flags=%b ovf=%0d exp=%b/%0d", flags, ovf_cnt, flags_m, ovf_m); end
    idle_inputs();
  endtask

  task automatic test_single_push();
    in_valid = 1; in_out = 16'h1234; in_status = 6'b000010; in_op = 3'b000; out_ready = 1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b exp=0", out_valid); end
    cycle();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_status !== 6'b000010)
      begin failures++; $display("FAIL single_out valid=%b data=%h st=%b exp=1/1234/000010", out_valid, out_data, out_status); end
    checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL single_occ1 got=%0d exp=1", occupancy); end
    cycle();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_drain occ=%0d valid=%b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    vals[0] = 16'hA001; vals[1] = 16'hB002; vals[2] = 16'hC003;
    out_ready = 0; in_op = 3'b000; in_flag_we = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_out = vals[i]; in_status = 6'(i + 1);
      cycle();
    end
    in_valid = 0;
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full occ=%0d rdy=%b exp=2/0", occupancy, in_ready); end
    checks++; if (out_data !== vals[0]) begin failures++; $display("FAIL b2b_hold got=%h exp=%h", out_data, vals[0]); end
    out_ready = 1;
    checks++; if (out_data !== vals[0] || out_status !== 6'd1) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=%h/1", out_data, out_status, vals[0]); end
    cycle();
    checks++; if (out_data !== vals[1] || out_status !== 6'd2) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=%h/2", out_data, out_status, vals[1]); end
    cycle();
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", occupancy); end
    out_ready = 0;
  endtask

  task automatic test_push_pop_same();
    in_valid = 1; in_out = 16'hD00D; in_status = 6'b0; out_ready = 0;
    cycle();
    in_out = 16'hE00E; out_ready = 1;
    cycle();
    in_valid = 0; out_ready = 0;
    checks++; if (occupancy !== 2'd1 || out_data !== 16'hE00E) begin failures++; $display("FAIL pushpop occ=%0d data=%h exp=1/e00e", occupancy, out_data); end
    out_ready = 1;
    cycle();
    out_ready = 0;
  endtask

  task automatic test_flags();
    out_ready = 1;
    in_valid = 1; in_op = 3'b101; in_status = 6'b100000; in_flag_we = 1; in_out = 16'h0F0F;
    cycle();
    checks++; if (flags !== 6'b100000 || cin_fb !== 1'b1) begin failures++; $display("FAIL flags_adc flags=%b cin=%b exp=100000/1", flags, cin_fb); end
    in_op = 3'b010; in_status = 6'b010000;
    cycle();
    checks++; if (flags !== 6'b100000) begin failures++; $display("FAIL flags_op010 got=%b exp=100000", flags); end
    in_op = 3'b100; in_status = 6'b001000; in_flag_we = 0;
    cycle();
    checks++; if (flags !== 6'b100000) begin failures++; $display("FAIL flags_we0 got=%b exp=100000", flags); end
    in_op = 3'b110; in_status = 6'b011001; in_flag_we = 1;
    cycle();
    in_valid = 0;
    checks++; if (flags !== 6'b011001 || cin_fb !== 1'b0) begin failures++; $display("FAIL flags_sub flags=%b cin=%b exp=011001/0", flags, cin_fb); end
    cycle();
  endtask

  task automatic test_ovf_saturate();
    out_ready = 1; in_flag_we = 0; in_op = 3'b100;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1; in_out = 16'(i); in_status = 6'b000100;
      cycle();
      if (i == 9) begin
        checks++; if (ovf_cnt !== 8'(ovf_m)) begin failures++; $display("FAIL ovf_mid got=%0d exp=%0d", ovf_cnt, ovf_m); end
      end
    end
    in_valid = 0;
    checks++; if (ovf_cnt !== 8'd255) begin failures++; $display("FAIL ovf_sat got=%0d exp=255", ovf_cnt); end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) == 0);
      in_out     = 16'($urandom);
      in_status  = 6'($urandom);
      in_op      = 3'($urandom);
      in_flag_we = 1'($urandom);
      cycle();
      checks++;
      if (occupancy !== 2'(q.size()) || out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)
          || flags !== flags_m || cin_fb !== flags_m[5] || ovf_cnt !== 8'(ovf_m)
          || (q.size() > 0 && {out_data, out_status} !== q[0])) begin
        failures++;
        $display("FAIL random[%0d] occ=%0d data=%h st=%b flags=%b ovf=%0d exp occ=%0d head=%h flags=%b ovf=%0d",
                 i, occupancy, out_data, out_status, flags, ovf_cnt, q.size(),
                 (q.size() > 0) ? q[0] : 22'h0, flags_m, ovf_m);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_op = 3'b001; in_flag_we = 1;
    in_valid = 1; in_out = 16'h1111; in_status = 6'b110100;
    cycle();
    in_out = 16'h2222;
    cycle();
    in_valid = 0;
    checks++; if (occupancy !== 2'd2 || flags === 6'h0 || ovf_cnt === 8'h0) begin failures++; $display("FAIL mid_setup occ=%0d flags=%b ovf=%0d exp=2/nonzero/nonzero", occupancy, flags, ovf_cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || flags !== 6'h0 || ovf_cnt !== 8'h0 || occupancy !== 2'd0)
      begin failures++; $display("FAIL mid_async valid=%b flags=%b ovf=%0d occ=%0d exp=0", out_valid, flags, ovf_cnt, occupancy); end
    checks++; if (in_ready !== 1'b0 || out_data !== 16'h0) begin failures++; $display("FAIL mid_async_rdy rdy=%b data=%h exp=0/0", in_ready, out_data); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1;
    cycle();
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0) begin failures++; $display("FAIL mid_release rdy=%b occ=%0d exp=1/0", in_ready, occupancy); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_push_pop_same();
    test_flags();
    test_ovf_saturate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter Width, default 16, meaning arithmetic result width in bits.
REQ-002 SHALL have parameter OVF_CNT_W, default 8, meaning width of the saturating overflow counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  high when the arithmetic unit's result is presented.
REQ-006 SHALL have port in_ready  output  1  high when the stage can accept a result.
REQ-007 SHALL have port in_out  input  Width  the arithmetic result (Out).
REQ-008 SHALL have port in_status  input  6  the arithmetic flags {C,Z,N,V,P,Af}, with C at bit 5 and Af at bit 0.
REQ-009 SHALL have port in_op  input  3  the opcode F that produced the result.
REQ-010 SHALL have port in_flag_we  input  1  high when the accepted result updates the architectural flags.
REQ-011 SHALL have port out_valid  output  1  high when a buffered result is available to the consumer.
REQ-012 SHALL have port out_ready  input  1  high when the consumer takes the result.
REQ-013 SHALL have port out_data  output  Width  the head-entry result.
REQ-014 SHALL have port out_status  output  6  the head-entry status.
REQ-015 SHALL have port flags  output  6  the architectural flag register, in the same bit order as in_status.
REQ-016 SHALL have port cin_fb  output  1  the carry fed back as Cin for ADC (101) and SBB (111); equals flags[5].
REQ-017 SHALL have port ovf_cnt  output  OVF_CNT_W  the count of accepted results with V=1.
REQ-018 SHALL have port occupancy  output  2  the number of buffered entries, 0 to 2.

Function
REQ-019 SHALL buffer results in a 2-entry FIFO holding {in_out, in_status}, with registered read and write pointers.
REQ-020 SHALL accept a result on any edge where in_valid and in_ready are both high (push).
REQ-021 SHALL pop the head entry on any edge where out_valid and out_ready are both high.
REQ-022 SHALL drive in_ready high exactly when occupancy is less than 2, derived only from registered state; it SHALL NOT depend on out_ready, so there is no combinational path from out_ready to in_ready.
REQ-023 SHALL drive out_valid high exactly when occupancy is not 0.
REQ-024 SHALL drive out_data and out_status from the head entry, and both SHALL hold steady while out_valid is high and out_ready is low.
REQ-025 SHALL present a pushed result on the outputs with 1-cycle latency: out_valid is high in the cycle after the push when the FIFO was empty, and there is no input-to-output bypass.
REQ-026 SHALL, on a simultaneous push and pop at occupancy 1, keep occupancy at 1 and make the new entry the head.
REQ-027 SHALL, when full (occupancy 2), allow only a pop, because in_ready is low.
REQ-028 SHALL wrap the pointers modulo 2.
REQ-029 SHALL treat an input with in_valid high while in_ready is low as no event: FIFO, flags and ovf_cnt are unchanged.
REQ-030 SHALL, on a push with in_flag_we=1 and in_op in {001,011,100,101,110,111}, load flags with in_status at that edge.
REQ-031 SHALL leave flags unchanged on a push with in_op in {000,010} or with in_flag_we=0.
REQ-032 SHALL, on a push with in_status[2]=1 (V), increment ovf_cnt by 1, saturating at its all-ones value; this happens regardless of in_flag_we.
REQ-033 SHALL make flags and cin_fb update at the push edge, independent of FIFO drain.

Reset
REQ-034 SHALL, while rst is high, asynchronously force occupancy=0, both pointers=0, flags=000000, ovf_cnt=0, out_valid=0, and in_ready=0.
REQ-035 SHALL force out_data=0 and out_status=0 during reset.
REQ-036 SHALL discard buffered entries when reset is asserted mid-operation; after deassertion in_ready goes high on the first clk edge.
REQ-037 SHALL ignore pushes and pops attempted in the cycle reset is released.

Structure
REQ-038 SHALL take the opcode constants (INC=001, DEC=011, ADD=100, ADC=101, SUB=110, SBB=111), the status bit indices (C=5, Z=4, N=3, V=2, P=1, Af=0) and STATUS_W=6 from the shared package alu_pkg.
REQ-039 SHALL implement the 2-entry buffer as the sub-module result_fifo (width Width+6), with the flag and counter logic kept in alu_result_stage.

Verification
REQ-040 SHALL cover: push 0x1234 with status 000010 into an empty FIFO, out_ready=1 -> out_valid=1 one cycle later with out_data=0x1234, then occupancy=0.
REQ-041 SHALL cover: three back-to-back pushes with out_ready=0 -> occupancy=2 and in_ready=0; the third is not accepted; releasing out_ready drains the first two entries in order.
REQ-042 SHALL cover: at occupancy 1, push and pop in the same cycle -> occupancy stays 1 and out_data becomes the new value.
REQ-043 SHALL cover: push op 101 with status 100000 and in_flag_we=1 -> flags=100000 and cin_fb=1; then push op 010 with status 010000 -> flags unchanged.
REQ-044 SHALL cover: 300 pushes with V=1 and OVF_CNT_W=8 -> ovf_cnt saturates at 255.
REQ-045 SHALL cover: assert rst with occupancy 2 and flags nonzero -> out_valid=0, flags=0 and ovf_cnt=0 immediately, without waiting for a clk edge.
